// File: rtl/insertion_sort_engine_pkg.sv
// Shared types and constants for the insertion sort engine.
package insertion_sort_engine_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_KEY,
    RD_CMP,
    WR_SHIFT,
    WR_KEY,
    FINISH
  } state_t;

  // Sub-phase of the memory transaction owned by the current state.
  // PH_DEC is the extra cycle in RD_CMP where the registered key/cmp pair is compared.
  typedef enum logic [1:0] {
    PH_REQ,
    PH_RESP,
    PH_DEC
  } phase_t;

  localparam int unsigned RESP_OKAY = 0;

endpackage

// File: rtl/insertion_sort_engine_sort_compare.sv
// Shift decision for insertion sort: strict compare so equal elements never move.
module sort_compare #(
  parameter int DATA_WDTH  = 32,
  parameter int SIGNED_CMP = 0
) (
  input  logic [DATA_WDTH-1:0] a,
  input  logic [DATA_WDTH-1:0] b,
  input  logic                 descending,
  output logic                 do_shift
);

  logic a_gt_b;
  logic a_lt_b;

  // a is the element already in place (cmp), b is the element being inserted (key).
  always_comb begin
    if (SIGNED_CMP != 0) begin
      a_gt_b = $signed(a) > $signed(b);
      a_lt_b = $signed(a) < $signed(b);
    end else begin
      a_gt_b = a > b;
      a_lt_b = a < b;
    end
    do_shift = descending ? a_lt_b : a_gt_b;
  end

endmodule

// File: rtl/insertion_sort_engine.sv
// In-place insertion sort over a simple AXI-like read/write memory port.
module insertion_sort_engine
  import insertion_sort_engine_pkg::*;
#(
  parameter int ADDR_WDTH  = 4,
  parameter int DATA_WDTH  = 32,
  parameter int RESP_WDTH  = 2,
  parameter int SIGNED_CMP = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   descending,
  input  logic [ADDR_WDTH:0]     arr_size,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [2*ADDR_WDTH:0]   shift_count,
  output logic                   ar_valid,
  input  logic                   ar_ready,
  output logic [ADDR_WDTH-1:0]   ar_address,
  input  logic                   r_valid,
  output logic                   r_ready,
  input  logic [DATA_WDTH-1:0]   r_data,
  output logic                   aw_valid,
  input  logic                   aw_ready,
  output logic [ADDR_WDTH-1:0]   aw_address,
  output logic                   w_valid,
  input  logic                   w_ready,
  output logic [DATA_WDTH-1:0]   w_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [RESP_WDTH-1:0]   b_resp
);

  localparam logic [ADDR_WDTH:0]   CNT_ONE   = (ADDR_WDTH+1)'(1);
  localparam logic [ADDR_WDTH-1:0] ADDR_ONE  = ADDR_WDTH'(1);
  localparam logic [2*ADDR_WDTH:0] SHIFT_ONE = (2*ADDR_WDTH+1)'(1);
  localparam logic [RESP_WDTH-1:0] OKAY      = RESP_WDTH'(RESP_OKAY);

  state_t               state;
  phase_t               phase;
  logic [ADDR_WDTH:0]   i;
  logic [ADDR_WDTH:0]   j;
  logic [ADDR_WDTH:0]   size;
  logic [DATA_WDTH-1:0] key;
  logic [DATA_WDTH-1:0] cmp;
  logic                 desc_q;
  logic                 do_shift;

  logic [ADDR_WDTH:0]   i_next;
  logic [ADDR_WDTH:0]   i_prev;
  logic [ADDR_WDTH:0]   j_prev;
  logic [ADDR_WDTH-1:0] j_succ_addr;
  logic                 wr_accepted;

  sort_compare #(
    .DATA_WDTH  (DATA_WDTH),
    .SIGNED_CMP (SIGNED_CMP)
  ) u_sort_compare (
    .a          (cmp),
    .b          (key),
    .descending (desc_q),
    .do_shift   (do_shift)
  );

  // Index arithmetic; j = -1 is all-ones, so j+1 wraps cleanly to address 0.
  always_comb begin
    i_next      = i + CNT_ONE;
    i_prev      = i - CNT_ONE;
    j_prev      = j - CNT_ONE;
    j_succ_addr = j[ADDR_WDTH-1:0] + ADDR_ONE;
    wr_accepted = (!aw_valid || aw_ready) && (!w_valid || w_ready);
  end

  // Sort FSM; each transition into a memory state launches that state's request
  // in the same edge so zero-wait memory costs two cycles per access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      phase       <= PH_REQ;
      i           <= '0;
      j           <= '0;
      size        <= '0;
      key         <= '0;
      cmp         <= '0;
      desc_q      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      shift_count <= '0;
      ar_valid    <= 1'b0;
      ar_address  <= '0;
      r_ready     <= 1'b0;
      aw_valid    <= 1'b0;
      aw_address  <= '0;
      w_valid     <= 1'b0;
      w_data      <= '0;
      b_ready     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            desc_q <= descending;
            size   <= arr_size;
            err    <= 1'b0;
            busy   <= 1'b1;
            if (arr_size <= CNT_ONE) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              i           <= CNT_ONE;
              shift_count <= '0;
              ar_valid    <= 1'b1;
              ar_address  <= ADDR_ONE;
              phase       <= PH_REQ;
              state       <= RD_KEY;
            end
          end
        end

        RD_KEY, RD_CMP: begin
          if (phase == PH_REQ) begin
            if (ar_ready) begin
              ar_valid <= 1'b0;
              r_ready  <= 1'b1;
              phase    <= PH_RESP;
            end
          end else if (phase == PH_RESP) begin
            if (r_valid) begin
              r_ready <= 1'b0;
              if (state == RD_KEY) begin
                key        <= r_data;
                j          <= i_prev;
                ar_valid   <= 1'b1;
                ar_address <= i_prev[ADDR_WDTH-1:0];
                phase      <= PH_REQ;
                state      <= RD_CMP;
              end else begin
                cmp   <= r_data;
                phase <= PH_DEC;
              end
            end
          end else begin
            if (do_shift) begin
              aw_valid   <= 1'b1;
              w_valid    <= 1'b1;
              aw_address <= j_succ_addr;
              w_data     <= cmp;
              phase      <= PH_REQ;
              state      <= WR_SHIFT;
            end else if (j != i_prev) begin
              aw_valid   <= 1'b1;
              w_valid    <= 1'b1;
              aw_address <= j_succ_addr;
              w_data     <= key;
              phase      <= PH_REQ;
              state      <= WR_KEY;
            end else begin
              // Key already in place: advance i without writing.
              i <= i_next;
              if (i_next == size) begin
                state <= FINISH;
                done  <= 1'b1;
              end else begin
                ar_valid   <= 1'b1;
                ar_address <= i_next[ADDR_WDTH-1:0];
                phase      <= PH_REQ;
                state      <= RD_KEY;
              end
            end
          end
        end

        WR_SHIFT, WR_KEY: begin
          if (phase == PH_REQ) begin
            if (aw_ready) aw_valid <= 1'b0;
            if (w_ready)  w_valid  <= 1'b0;
            if (wr_accepted) begin
              b_ready <= 1'b1;
              phase   <= PH_RESP;
            end
          end else if (b_valid) begin
            b_ready <= 1'b0;
            if (b_resp != OKAY) begin
              err   <= 1'b1;
              state <= FINISH;
              done  <= 1'b1;
            end else if (state == WR_SHIFT) begin
              shift_count <= shift_count + SHIFT_ONE;
              if (j == '0) begin
                j          <= '1;
                aw_valid   <= 1'b1;
                w_valid    <= 1'b1;
                aw_address <= '0;
                w_data     <= key;
                phase      <= PH_REQ;
                state      <= WR_KEY;
              end else begin
                j          <= j_prev;
                ar_valid   <= 1'b1;
                ar_address <= j_prev[ADDR_WDTH-1:0];
                phase      <= PH_REQ;
                state      <= RD_CMP;
              end
            end else begin
              i <= i_next;
              if (i_next == size) begin
                state <= FINISH;
                done  <= 1'b1;
              end else begin
                ar_valid   <= 1'b1;
                ar_address <= i_next[ADDR_WDTH-1:0];
                phase      <= PH_REQ;
                state      <= RD_KEY;
              end
            end
          end
        end

        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_insertion_sort_engine.sv
// Directed bench: memory responder with optional stalls, protocol monitor,
// and one task per scenario. Two engines (unsigned/signed compare) share the memory.
module tb_insertion_sort_engine;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int RW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic          descending = 1'b0;
  logic [AW:0]   arr_size = '0;
  logic          sel = 1'b0;
  logic          start_v [2];

  logic          busy_v [2], done_v [2], err_v [2];
  logic [2*AW:0] shift_count_v [2];
  logic          ar_valid_v [2], r_ready_v [2], aw_valid_v [2], w_valid_v [2], b_ready_v [2];
  logic [AW-1:0] ar_address_v [2], aw_address_v [2];
  logic [DW-1:0] w_data_v [2];

  logic          ar_ready = 1'b0, r_valid = 1'b0, aw_ready = 1'b0, w_ready = 1'b0, b_valid = 1'b0;
  logic [DW-1:0] r_data = '0;
  logic [RW-1:0] b_resp = '0;

  logic          busy, done, err, ar_valid, r_ready, aw_valid, w_valid, b_ready;
  logic [2*AW:0] shift_count;
  logic [AW-1:0] ar_address, aw_address;
  logic [DW-1:0] w_data;

  assign start_v[0]  = start && !sel;
  assign start_v[1]  = start && sel;
  assign busy        = busy_v[sel];
  assign done        = done_v[sel];
  assign err         = err_v[sel];
  assign shift_count = shift_count_v[sel];
  assign ar_valid    = ar_valid_v[sel];
  assign ar_address  = ar_address_v[sel];
  assign r_ready     = r_ready_v[sel];
  assign aw_valid    = aw_valid_v[sel];
  assign aw_address  = aw_address_v[sel];
  assign w_valid     = w_valid_v[sel];
  assign w_data      = w_data_v[sel];
  assign b_ready     = b_ready_v[sel];

  insertion_sort_engine #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW), .SIGNED_CMP(0)) u_dut (
    .clk(clk), .rst(rst), .start(start_v[0]), .descending(descending), .arr_size(arr_size),
    .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]), .shift_count(shift_count_v[0]),
    .ar_valid(ar_valid_v[0]), .ar_ready(ar_ready), .ar_address(ar_address_v[0]),
    .r_valid(r_valid), .r_ready(r_ready_v[0]), .r_data(r_data),
    .aw_valid(aw_valid_v[0]), .aw_ready(aw_ready), .aw_address(aw_address_v[0]),
    .w_valid(w_valid_v[0]), .w_ready(w_ready), .w_data(w_data_v[0]),
    .b_valid(b_valid), .b_ready(b_ready_v[0]), .b_resp(b_resp)
  );

  insertion_sort_engine #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW), .SIGNED_CMP(1)) u_dut_signed (
    .clk(clk), .rst(rst), .start(start_v[1]), .descending(descending), .arr_size(arr_size),
    .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]), .shift_count(shift_count_v[1]),
    .ar_valid(ar_valid_v[1]), .ar_ready(ar_ready), .ar_address(ar_address_v[1]),
    .r_valid(r_valid), .r_ready(r_ready_v[1]), .r_data(r_data),
    .aw_valid(aw_valid_v[1]), .aw_ready(aw_ready), .aw_address(aw_address_v[1]),
    .w_valid(w_valid_v[1]), .w_ready(w_ready), .w_data(w_data_v[1]),
    .b_valid(b_valid), .b_ready(b_ready_v[1]), .b_resp(b_resp)
  );

  // Memory model and monitor state
  logic [DW-1:0] mem [16];
  int unsigned   mode = 0;          // 0 zero-wait, 1 random stalls, 2 never ready
  bit            err_next = 1'b0;   // next write response is SLVERR
  bit            err_seen = 1'b0;
  bit            rd_pending = 1'b0, aw_got = 1'b0, w_got = 1'b0;
  logic [AW-1:0] rd_addr, wa;
  logic [DW-1:0] wd;
  bit            ar_hold = 1'b0, aw_hold = 1'b0, w_hold = 1'b0;
  logic [AW-1:0] ar_hold_addr, aw_hold_addr;
  logic [DW-1:0] w_hold_data;
  int unsigned   viol = 0, done_cnt = 0, aw_cycles = 0, n_ar = 0, n_aw = 0, post_err = 0;
  logic [AW-1:0] wl_addr [$];
  logic [DW-1:0] wl_data [$];

  int checks = 0;
  int fails  = 0;

  function automatic bit go();
    if (mode == 0) return 1'b1;
    if (mode == 1) return $urandom_range(0, 1) == 1;
    return 1'b0;
  endfunction

  // Responder and protocol monitor, evaluated on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        ar_ready = 0; r_valid = 0; aw_ready = 0; w_ready = 0; b_valid = 0;
        rd_pending = 0; aw_got = 0; w_got = 0; ar_hold = 0; aw_hold = 0; w_hold = 0;
        continue;
      end
      if (ar_hold && (!ar_valid || ar_address !== ar_hold_addr)) viol++;
      if (aw_hold && (!aw_valid || aw_address !== aw_hold_addr)) viol++;
      if (w_hold && (!w_valid || w_data !== w_hold_data)) viol++;
      if (ar_valid && (aw_valid || w_valid || aw_got || w_got || rd_pending)) viol++;
      if ((aw_valid || w_valid) && rd_pending) viol++;
      if (aw_valid) aw_cycles++;
      if (done) done_cnt++;
      if (err_seen && (ar_valid || aw_valid)) post_err++;

      if (aw_got && w_got) begin
        b_valid = b_valid || go();
        b_resp  = err_next ? 2'd2 : 2'd0;
        if (b_valid && b_ready) begin
          if (err_next) begin
            err_next = 0;
            err_seen = 1;
          end else begin
            mem[wa] = wd;
            wl_addr.push_back(wa);
            wl_data.push_back(wd);
          end
          aw_got = 0;
          w_got  = 0;
        end
      end else begin
        b_valid = 0;
      end

      if (rd_pending) begin
        r_valid = r_valid || go();
        r_data  = mem[rd_addr];
        if (r_valid && r_ready) rd_pending = 0;
      end else begin
        r_valid = 0;
      end

      ar_ready = ar_valid && !rd_pending && go();
      if (ar_valid && ar_ready) begin rd_pending = 1; rd_addr = ar_address; n_ar++; end
      aw_ready = aw_valid && !aw_got && go();
      if (aw_valid && aw_ready) begin aw_got = 1; wa = aw_address; n_aw++; end
      w_ready = w_valid && !w_got && go();
      if (w_valid && w_ready) begin w_got = 1; wd = w_data; end

      ar_hold = ar_valid && !ar_ready;   ar_hold_addr = ar_address;
      aw_hold = aw_valid && !aw_ready;   aw_hold_addr = aw_address;
      w_hold  = w_valid && !w_ready;     w_hold_data  = w_data;
    end
  end

  task automatic run_sort(input logic [AW:0] n, input logic d, input int unsigned budget,
                          output bit finished);
    int unsigned d0;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; arr_size = n; descending = d;
    @(posedge clk); #1;
    start = 1'b0;
    finished = 1'b0;
    for (int unsigned c = 0; c < budget && !finished; c++) begin
      if (done_cnt != d0) finished = 1'b1;
      else begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, err, ar_valid, r_ready, aw_valid, w_valid, b_ready} !== 8'h00) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 00000000",
               {busy, done, err, ar_valid, r_ready, aw_valid, w_valid, b_ready});
    end
    checks++;
    if ({shift_count, ar_address, aw_address, w_data} !== '0) begin
      fails++;
      $display("FAIL reset_data: shift_count=%0d ar=%0d aw=%0d w=%h expected all 0",
               shift_count, ar_address, aw_address, w_data);
    end
  endtask

  task automatic test_basic();
    bit fin;
    int unsigned d0;
    logic [DW-1:0] exp3 [3];
    exp3 = '{32'd1, 32'd2, 32'd3};
    mem[0] = 3; mem[1] = 1; mem[2] = 2;
    d0 = done_cnt;
    run_sort(5'd3, 1'b0, 200, fin);
    checks++;
    if (fin !== 1'b1) begin fails++; $display("FAIL basic_timeout: done seen=%0b expected 1", fin); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (mem[k] !== exp3[k]) begin fails++; $display("FAIL basic_mem[%0d]: got %0d expected %0d", k, mem[k], exp3[k]); end
    end
    checks++;
    if (shift_count !== 9'd2) begin fails++; $display("FAIL basic_shifts: got %0d expected 2", shift_count); end
    checks++;
    if (done_cnt - d0 !== 1) begin fails++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt - d0); end
    checks++;
    if ({err, busy} !== 2'b00) begin fails++; $display("FAIL basic_err_busy: got %b expected 00", {err, busy}); end
  endtask

  task automatic test_presorted();
    bit fin;
    int unsigned a0;
    mem[0] = 1; mem[1] = 2; mem[2] = 3; mem[3] = 4;
    a0 = aw_cycles;
    run_sort(5'd4, 1'b0, 200, fin);
    checks++;
    if (fin !== 1'b1) begin fails++; $display("FAIL presorted_timeout: done seen=%0b expected 1", fin); end
    checks++;
    if (aw_cycles - a0 !== 0) begin fails++; $display("FAIL presorted_no_write: aw_valid cycles=%0d expected 0", aw_cycles - a0); end
    checks++;
    if (shift_count !== 9'd0) begin fails++; $display("FAIL presorted_shifts: got %0d expected 0", shift_count); end
    checks++;
    if ({mem[0], mem[1], mem[2], mem[3]} !== {32'd1, 32'd2, 32'd3, 32'd4}) begin
      fails++; $display("FAIL presorted_mem: got %0d %0d %0d %0d expected 1 2 3 4", mem[0], mem[1], mem[2], mem[3]);
    end
  endtask

  // [2,7a,7b,5] descending. Each key write places the element read at A[i]:
  // 7a lands at 0 (i=1), 7b at 1 (i=2), so the write trace pins the order of the 7s.
  task automatic test_stable_descending();
    bit fin;
    logic [AW-1:0] ea [6];
    logic [DW-1:0] ed [6];
    ea = '{4'd1, 4'd0, 4'd2, 4'd1, 4'd3, 4'd2};
    ed = '{32'd2, 32'd7, 32'd2, 32'd7, 32'd2, 32'd5};
    mem[0] = 2; mem[1] = 7; mem[2] = 7; mem[3] = 5;
    wl_addr.delete(); wl_data.delete();
    run_sort(5'd4, 1'b1, 300, fin);
    checks++;
    if (fin !== 1'b1) begin fails++; $display("FAIL stable_timeout: done seen=%0b expected 1", fin); end
    checks++;
    if ({mem[0], mem[1], mem[2], mem[3]} !== {32'd7, 32'd7, 32'd5, 32'd2}) begin
      fails++; $display("FAIL stable_mem: got %0d %0d %0d %0d expected 7 7 5 2", mem[0], mem[1], mem[2], mem[3]);
    end
    checks++;
    if (shift_count !== 9'd3) begin fails++; $display("FAIL stable_shifts: got %0d expected 3", shift_count); end
    checks++;
    if (wl_addr.size() !== 6) begin fails++; $display("FAIL stable_write_count: got %0d expected 6", wl_addr.size()); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (k >= wl_addr.size()) begin
        fails++; $display("FAIL stable_write[%0d]: missing, expected A[%0d]=%0d", k, ea[k], ed[k]);
      end else if (wl_addr[k] !== ea[k] || wl_data[k] !== ed[k]) begin
        fails++; $display("FAIL stable_write[%0d]: got A[%0d]=%0d expected A[%0d]=%0d", k, wl_addr[k], wl_data[k], ea[k], ed[k]);
      end
    end
  endtask

  task automatic test_signed_compare();
    bit fin;
    sel = 1'b1;
    mem[0] = 32'hFFFF_FFFF; mem[1] = 32'd1;
    run_sort(5'd2, 1'b0, 200, fin);
    checks++;
    if (fin !== 1'b1) begin fails++; $display("FAIL signed_timeout: done seen=%0b expected 1", fin); end
    checks++;
    if ({mem[0], mem[1]} !== {32'hFFFF_FFFF, 32'd1}) begin
      fails++; $display("FAIL signed_mem: got %h %h expected ffffffff 00000001", mem[0], mem[1]);
    end
    sel = 1'b0;
    mem[0] = 32'hFFFF_FFFF; mem[1] = 32'd1;
    run_sort(5'd2, 1'b0, 200, fin);
    checks++;
    if (fin !== 1'b1) begin fails++; $display("FAIL unsigned_timeout: done seen=%0b expected 1", fin); end
    checks++;
    if ({mem[0], mem[1]} !== {32'd1, 32'hFFFF_FFFF}) begin
      fails++; $display("FAIL unsigned_mem: got %h %h expected 00000001 ffffffff", mem[0], mem[1]);
    end
    checks++;
    if (shift_count !== 9'd1) begin fails++; $display("FAIL unsigned_shifts: got %0d expected 1", shift_count); end
  endtask

  task automatic test_random_stalls();
    bit fin;
    int unsigned v0;
    logic [DW-1:0] src [16];
    logic [DW-1:0] exp16 [16];
    src   = '{32'd9, 32'd3, 32'd15, 32'd0, 32'd12, 32'd7, 32'd7, 32'd1,
              32'd14, 32'd2, 32'd11, 32'd5, 32'd10, 32'd4, 32'd13, 32'd6};
    exp16 = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7,
              32'd7, 32'd9, 32'd10, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15};
    for (int k = 0; k < 16; k++) mem[k] = src[k];
    v0 = viol;
    mode = 1;
    run_sort(5'd16, 1'b0, 20000, fin);
    mode = 0;
    checks++;
    if (fin !== 1'b1) begin fails++; $display("FAIL stall_timeout: done seen=%0b expected 1", fin); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (mem[k] !== exp16[k]) begin fails++; $display("FAIL stall_mem[%0d]: got %0d expected %0d", k, mem[k], exp16[k]); end
    end
    checks++;
    if (viol - v0 !== 0) begin fails++; $display("FAIL stall_protocol: violations=%0d expected 0", viol - v0); end
  endtask

  task automatic test_write_error();
    bit fin;
    int unsigned d0, a0;
    mem[0] = 3; mem[1] = 1; mem[2] = 2;
    err_seen = 1'b0;
    err_next = 1'b1;
    d0 = done_cnt; a0 = n_aw;
    run_sort(5'd3, 1'b0, 200, fin);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (fin !== 1'b1) begin fails++; $display("FAIL berr_timeout: done seen=%0b expected 1", fin); end
    checks++;
    if (err !== 1'b1) begin fails++; $display("FAIL berr_err: got %b expected 1", err); end
    checks++;
    if (done_cnt - d0 !== 1) begin fails++; $display("FAIL berr_done_pulses: got %0d expected 1", done_cnt - d0); end
    checks++;
    if (post_err !== 0) begin fails++; $display("FAIL berr_no_more_txn: valid cycles after error=%0d expected 0", post_err); end
    checks++;
    if (n_aw - a0 !== 1) begin fails++; $display("FAIL berr_aw_count: got %0d expected 1", n_aw - a0); end
    err_seen = 1'b0;
  endtask

  task automatic test_size_one();
    bit got;
    int unsigned r0;
    r0 = n_ar;
    @(posedge clk); #1;
    start = 1'b1; arr_size = 5'd1; descending = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 2 && !got; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    checks++;
    if (got !== 1'b1) begin fails++; $display("FAIL size1_done: done within 2 cycles=%0b expected 1", got); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (n_ar - r0 !== 0) begin fails++; $display("FAIL size1_no_read: reads=%0d expected 0", n_ar - r0); end
  endtask

  task automatic test_reset_mid_read();
    bit fin;
    mode = 2;
    mem[0] = 3; mem[1] = 1; mem[2] = 2;
    @(posedge clk); #1;
    start = 1'b1; arr_size = 5'd3; descending = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, ar_valid} !== 2'b11) begin fails++; $display("FAIL midread_stalled: busy,ar_valid=%b expected 11", {busy, ar_valid}); end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, err, ar_valid, r_ready, aw_valid, w_valid, b_ready, shift_count, ar_address, aw_address, w_data} !== '0) begin
      fails++;
      $display("FAIL midread_reset: busy=%b ar_valid=%b ar=%0d r_ready=%b expected all 0", busy, ar_valid, ar_address, r_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    mode = 0;
    run_sort(5'd3, 1'b0, 200, fin);
    checks++;
    if ({fin, mem[0], mem[1], mem[2]} !== {1'b1, 32'd1, 32'd2, 32'd3}) begin
      fails++; $display("FAIL post_reset_sort: fin=%b got %0d %0d %0d expected 1 1 2 3", fin, mem[0], mem[1], mem[2]);
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    test_basic();
    test_presorted();
    test_stable_descending();
    test_signed_compare();
    test_random_stalls();
    test_write_error();
    test_size_one();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/insertion_sort_engine.md
INSERTION_SORT_ENGINE -- requirements
Module: insertion_sort_engine

Interface
REQ-001 SHALL have parameter ADDR_WDTH, default 4, array address width; maximum array length is 2**ADDR_WDTH.
REQ-002 SHALL have parameter DATA_WDTH, default 32, element width.
REQ-003 SHALL have parameter RESP_WDTH, default 2, write-response width; value 0 means OKAY.
REQ-004 SHALL have parameter SIGNED_CMP, default 0; value 1 selects two's-complement comparison, value 0 selects unsigned.
REQ-005 SHALL have ports: clk in 1, the single clock; rst in 1, asynchronous active-high reset.
REQ-006 SHALL have ports: start in 1; descending in 1, sampled at start; arr_size in ADDR_WDTH+1, sampled at start.
REQ-007 SHALL have ports: busy out 1; done out 1, a one-cycle pulse; err out 1, sticky until next start; shift_count out 2*ADDR_WDTH+1.
REQ-008 SHALL have ports: ar_valid out 1; ar_ready in 1; ar_address out ADDR_WDTH.
REQ-009 SHALL have ports: r_valid in 1; r_ready out 1; r_data in DATA_WDTH.
REQ-010 SHALL have ports: aw_valid out 1; aw_ready in 1; aw_address out ADDR_WDTH; w_valid out 1; w_ready in 1; w_data out DATA_WDTH.
REQ-011 SHALL have ports: b_valid in 1; b_ready out 1; b_resp in RESP_WDTH.

Function
REQ-012 SHALL sort the array in place using insertion sort. Ascending order applies when descending=0.
REQ-013 SHALL be stable: shift only while A[j] > key (ascending) or A[j] < key (descending); equal elements never move.
REQ-014 SHALL use FSM states IDLE, RD_KEY, RD_CMP, WR_SHIFT, WR_KEY, FINISH.
REQ-015 SHALL leave IDLE on start. If arr_size <= 1, go to FINISH. Otherwise set i=1, set shift_count=0, clear err, and go to RD_KEY.
REQ-016 SHALL ignore start while busy.
REQ-017 RD_KEY SHALL read A[i] into key, set j=i-1, and go to RD_CMP.
REQ-018 RD_CMP SHALL read A[j] into cmp.
- If the shift condition holds: go to WR_SHIFT.
- Otherwise: go to WR_KEY if j != i-1; if j == i-1, skip the write and advance i.
REQ-019 WR_SHIFT SHALL write cmp to A[j+1] and increment shift_count. If j==0, set j=-1 and go to WR_KEY; otherwise set j=j-1 and go to RD_CMP.
REQ-020 WR_KEY SHALL write key to A[j+1], then advance i.
REQ-021 Advancing i SHALL set i=i+1. If the new i equals arr_size, go to FINISH; otherwise go to RD_KEY.
REQ-022 Counters i and j SHALL be ADDR_WDTH+1 bits wide; j=-1 SHALL be representable without address wrap.
REQ-023 A read SHALL proceed as follows:
- assert ar_valid with ar_address and hold both stable until ar_ready;
- then assert r_ready and capture r_data on the r_valid&&r_ready cycle.
REQ-024 A write SHALL proceed as follows:
- assert aw_valid and w_valid in the same cycle;
- deassert each one independently when it is accepted;
- after both are accepted, assert b_ready until b_valid.
REQ-025 A write SHALL raise err when b_resp != 0. It SHALL then abort to FINISH with no further transactions.
REQ-026 At most one memory transaction SHALL be outstanding at a time.
REQ-027 FINISH SHALL pulse done for one cycle and return to IDLE. busy SHALL be high in every state except IDLE.
REQ-028 Comparisons SHALL be combinational on key and cmp. Each memory handshake SHALL add at least one cycle; zero-wait memory gives a minimum of 2 cycles per read and 2 per write.

Reset
REQ-029 rst SHALL force state IDLE immediately, including mid-transaction.
REQ-030 rst SHALL clear every output: all valid/ready signals, busy, done, err, shift_count, and all addresses and data.
REQ-031 rst SHALL clear internal registers i, j, key, cmp, size and the mode latch.

Structure
REQ-032 A shared package SHALL hold the FSM state enum and the OKAY response constant.
REQ-033 The comparator SHALL be one sub-module, sort_compare, parameterised by DATA_WDTH and SIGNED_CMP, with inputs a, b, descending and output do_shift.

Verification
REQ-034 Input [3,1,2], ascending, zero-wait memory -> [1,2,3], shift_count=2, done pulses once, err=0.
REQ-035 Input [1,2,3,4], ascending -> no writes issued (aw_valid never high), shift_count=0.
REQ-036 Input [2,7,7,5] with descending=1; equal 7s tagged by index -> [7,7,5,2], equal 7s keep their original order.
REQ-037 Input [0xFFFFFFFF,1] with SIGNED_CMP=1 -> [0xFFFFFFFF,1]; the same input with SIGNED_CMP=0 -> [1,0xFFFFFFFF].
REQ-038 Random ready/valid stalls, arr_size=16 -> sorted result; valid signals never drop before handshake; addresses stable while valid.
REQ-039 Cases: b_resp=2 on the first write -> err=1, done pulses, no further AR/AW. arr_size=1 -> done within 2 cycles of start. rst mid-read -> IDLE with all outputs 0.
